tank_motion_ctrl: RTL and testbench

//  Sequences tank movement from the button decoder's direction/moving outputs.
//  A free-running tick divider paces motion. A TURN/MOVE state machine spends

---
 rtl/tank_pkg.sv | 37 +++
 rtl/tick_gen.sv | 27 ++
 rtl/tank_motion_ctrl.sv | 127 ++++++++++++
 tb/tb_tank_motion_ctrl.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tank_pkg.sv
// Shared tank constants: direction codes, controller state encodings, arena geometry
// and saturating coordinate step helpers.
package tank_pkg;

  localparam int ARENA_W   = 640;
  localparam int ARENA_H   = 480;
  localparam int TANK_SIZE = 32;
  localparam int POS_W     = 10;

  typedef enum logic [2:0] {
    DIR_LEFT  = 3'b000,
    DIR_RIGHT = 3'b001,
    DIR_UP    = 3'b010,
    DIR_DOWN  = 3'b011
  } dir_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_TURN = 2'b01,
    ST_MOVE = 2'b10
  } state_e;

  function automatic logic [POS_W-1:0] step_down(input logic [POS_W-1:0] p,
                                                 input logic [POS_W-1:0] s);
    return (p < s) ? '0 : p - s;
  endfunction

  // Extra bit on the sum so a step near the top of the range cannot wrap.
  function automatic logic [POS_W-1:0] step_up(input logic [POS_W-1:0] p,
                                               input logic [POS_W-1:0] s,
                                               input logic [POS_W-1:0] lim);
    logic [POS_W:0] sum;
    sum = {1'b0, p} + {1'b0, s};
    return (sum > {1'b0, lim}) ? lim : sum[POS_W-1:0];
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running divider: tick is high for the single cycle in which the count
// reaches DIV-1, then the count wraps to zero.
module tick_gen #(
  parameter int DIV = 1_000_000
) (
  input  logic clk_100mhz,
  input  logic rst,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_q;

  assign tick = (cnt_q == CW'(DIV - 1));

  always_ff @(posedge clk_100mhz or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/tank_motion_ctrl.sv
// Tank motion sequencer: turns toward the requested heading for TURN_TICKS ticks,
// then steps the position once per tick, clamped to the arena and gated by blocked.
module tank_motion_ctrl
  import tank_pkg::*;
#(
  parameter int TICK_DIV   = 1_000_000,
  parameter int TURN_TICKS = 2,
  parameter int STEP       = 2,
  parameter int X_MAX      = ARENA_W - TANK_SIZE,
  parameter int Y_MAX      = ARENA_H - TANK_SIZE,
  parameter int X_INIT     = 304,
  parameter int Y_INIT     = 400
) (
  input  logic             clk_100mhz,
  input  logic             rst,
  input  logic [2:0]       direct,
  input  logic             moving,
  input  logic             blocked,
  output logic [POS_W-1:0] pos_x,
  output logic [POS_W-1:0] pos_y,
  output logic [2:0]       heading,
  output logic [1:0]       state,
  output logic             step_pulse,
  output logic             bump_pulse
);

  localparam int TW = $clog2(TURN_TICKS + 1);

  logic tick;

  tick_gen #(.DIV(TICK_DIV)) u_tick_gen (
    .clk_100mhz (clk_100mhz),
    .rst        (rst),
    .tick       (tick)
  );

  state_e           state_q;
  logic [2:0]       heading_q;
  logic [TW-1:0]    turn_cnt_q;
  logic [POS_W-1:0] pos_x_q, pos_y_q;
  logic             step_q, bump_q;

  logic             req, change;
  logic [POS_W-1:0] step_x_d, step_y_d;
  logic             at_limit;

  assign req    = moving & ~direct[2];
  assign change = req & (direct != heading_q);

  always_comb begin
    step_x_d = pos_x_q;
    step_y_d = pos_y_q;
    case (heading_q)
      DIR_LEFT:  step_x_d = step_down(pos_x_q, POS_W'(STEP));
      DIR_RIGHT: step_x_d = step_up(pos_x_q, POS_W'(STEP), POS_W'(X_MAX));
      DIR_UP:    step_y_d = step_down(pos_y_q, POS_W'(STEP));
      DIR_DOWN:  step_y_d = step_up(pos_y_q, POS_W'(STEP), POS_W'(Y_MAX));
      default:   ;
    endcase
  end

  // A clamped step that lands where we already are counts as hitting the wall.
  assign at_limit = (step_x_d == pos_x_q) && (step_y_d == pos_y_q);

  always_ff @(posedge clk_100mhz or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      heading_q  <= DIR_UP;
      turn_cnt_q <= '0;
      pos_x_q    <= POS_W'(X_INIT);
      pos_y_q    <= POS_W'(Y_INIT);
      step_q     <= 1'b0;
      bump_q     <= 1'b0;
    end else begin
      step_q <= 1'b0;
      bump_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (change) begin
            state_q    <= ST_TURN;
            heading_q  <= direct;
            turn_cnt_q <= TW'(TURN_TICKS);
          end else if (req) begin
            state_q <= ST_MOVE;
          end
        end
        ST_TURN: begin
          if (change) begin
            heading_q  <= direct;
            turn_cnt_q <= TW'(TURN_TICKS);
          end else if (tick) begin
            turn_cnt_q <= turn_cnt_q - TW'(1);
            if (turn_cnt_q == TW'(1)) begin
              state_q <= req ? ST_MOVE : ST_IDLE;
            end
          end
        end
        ST_MOVE: begin
          if (!req) begin
            state_q <= ST_IDLE;
          end else if (change) begin
            state_q    <= ST_TURN;
            heading_q  <= direct;
            turn_cnt_q <= TW'(TURN_TICKS);
          end else if (tick) begin
            if (blocked || at_limit) begin
              bump_q <= 1'b1;
            end else begin
              pos_x_q <= step_x_d;
              pos_y_q <= step_y_d;
              step_q  <= 1'b1;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign pos_x      = pos_x_q;
  assign pos_y      = pos_y_q;
  assign heading    = heading_q;
  assign state      = state_q;
  assign step_pulse = step_q;
  assign bump_pulse = bump_q;

endmodule

// File: tb/tb_tank_motion_ctrl.sv
// Bench for tank_motion_ctrl: a directed vector table, hand-written corner sequences
// and random stimulus, all checked against a cycle reference model of the motion rules.
module tb_tank_motion_ctrl;

  localparam int TICK_DIV   = 4;
  localparam int TURN_TICKS = 2;
  localparam int STEP       = 2;
  localparam int X_MAX      = 608;
  localparam int Y_MAX      = 448;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] direct = 3'b010;
  logic       moving = 1'b0;
  logic       blocked = 1'b0;

  logic [9:0] px [2];
  logic [9:0] py [2];
  logic [2:0] hd [2];
  logic [1:0] st [2];
  logic       sp [2];
  logic       bp [2];

  int n_pass = 0;
  int n_tot  = 0;
  int cyc    = 0;

  always #5 clk = ~clk;

  tank_motion_ctrl #(
    .TICK_DIV(TICK_DIV), .TURN_TICKS(TURN_TICKS), .STEP(STEP),
    .X_MAX(X_MAX), .Y_MAX(Y_MAX), .X_INIT(304), .Y_INIT(400)
  ) u_dut (
    .clk_100mhz(clk), .rst(rst), .direct(direct), .moving(moving), .blocked(blocked),
    .pos_x(px[0]), .pos_y(py[0]), .heading(hd[0]), .state(st[0]),
    .step_pulse(sp[0]), .bump_pulse(bp[0])
  );

  // Second instance starts next to the left and bottom walls.
  tank_motion_ctrl #(
    .TICK_DIV(TICK_DIV), .TURN_TICKS(TURN_TICKS), .STEP(STEP),
    .X_MAX(X_MAX), .Y_MAX(Y_MAX), .X_INIT(1), .Y_INIT(447)
  ) u_edge (
    .clk_100mhz(clk), .rst(rst), .direct(direct), .moving(moving), .blocked(blocked),
    .pos_x(px[1]), .pos_y(py[1]), .heading(hd[1]), .state(st[1]),
    .step_pulse(sp[1]), .bump_pulse(bp[1])
  );

  typedef struct {
    int x, y, hd, st, tc, sp, bp;
  } mdl_t;

  mdl_t m [2];

  typedef struct {
    int dir, mv, blk, n, ex, ey, ehd, est;
  } vec_t;

  vec_t tbl [$];

  function automatic mdl_t mdl_step(mdl_t c, int dir, int mv, int blk, int tk);
    mdl_t n;
    int   tx, ty;
    bit   rq;
    n    = c;
    n.sp = 0;
    n.bp = 0;
    rq   = (mv != 0) && (dir < 4);
    // Any valid request for a new heading restarts the turn, whatever the state.
    if (rq && dir != c.hd) begin
      n.st = 1;
      n.hd = dir;
      n.tc = TURN_TICKS;
      return n;
    end
    case (c.st)
      0: if (rq) n.st = 2;
      1: if (tk != 0) begin
        n.tc = c.tc - 1;
        if (n.tc == 0) n.st = rq ? 2 : 0;
      end
      2: if (!rq) n.st = 0;
         else if (tk != 0) begin
           tx = c.x;
           ty = c.y;
           case (c.hd)
             0: tx = (c.x - STEP < 0) ? 0 : c.x - STEP;
             1: tx = (c.x + STEP > X_MAX) ? X_MAX : c.x + STEP;
             2: ty = (c.y - STEP < 0) ? 0 : c.y - STEP;
             3: ty = (c.y + STEP > Y_MAX) ? Y_MAX : c.y + STEP;
             default: ;
           endcase
           if (blk != 0 || (tx == c.x && ty == c.y)) n.bp = 1;
           else begin
             n.x  = tx;
             n.y  = ty;
             n.sp = 1;
           end
         end
      default: ;
    endcase
    return n;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s cyc=%0d: got %0d, expected %0d", name, cyc, act, exp);
  endtask

  task automatic cmp_models();
    for (int i = 0; i < 2; i++) begin
      n_tot++;
      if (int'(px[i]) == m[i].x && int'(py[i]) == m[i].y && int'(hd[i]) == m[i].hd &&
          int'(st[i]) == m[i].st && int'(sp[i]) == m[i].sp && int'(bp[i]) == m[i].bp) begin
        n_pass++;
      end else begin
        $display("FAIL model[%0d] cyc=%0d: got x=%0d y=%0d hd=%0d st=%0d step=%0d bump=%0d, expected x=%0d y=%0d hd=%0d st=%0d step=%0d bump=%0d",
                 i, cyc, px[i], py[i], hd[i], st[i], sp[i], bp[i],
                 m[i].x, m[i].y, m[i].hd, m[i].st, m[i].sp, m[i].bp);
      end
    end
  endtask

  task automatic cycle();
    mdl_t nm [2];
    int   tk;
    tk = (cyc % TICK_DIV == TICK_DIV - 1) ? 1 : 0;
    for (int i = 0; i < 2; i++)
      nm[i] = mdl_step(m[i], int'(direct), int'(moving), int'(blocked), tk);
    @(posedge clk);
    #1;
    cyc++;
    m = nm;
    cmp_models();
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    direct  = 3'b010;
    moving  = 1'b0;
    blocked = 1'b0;
    @(posedge clk);
    #1;
    rst  = 1'b0;
    cyc  = 0;
    m[0] = '{x: 304, y: 400, hd: 2, st: 0, tc: 0, sp: 0, bp: 0};
    m[1] = '{x: 1,   y: 447, hd: 2, st: 0, tc: 0, sp: 0, bp: 0};
    cmp_models();
  endtask

  task automatic add(input int d, input int mv, input int b, input int n,
                     input int ex, input int ey, input int ehd, input int est);
    vec_t v;
    v = '{dir: d, mv: mv, blk: b, n: n, ex: ex, ey: ey, ehd: ehd, est: est};
    tbl.push_back(v);
  endtask

  initial begin
    // dir, moving, blocked, cycles | expected x, y, heading, state of the main tank
    add(2, 0, 0, 20, 304, 400, 2, 0);
    add(2, 1, 0, 12, 304, 394, 2, 2);
    add(0, 1, 0,  1, 304, 394, 0, 1);
    add(0, 1, 0,  7, 304, 394, 0, 2);
    add(0, 1, 0,  4, 302, 394, 0, 2);
    add(0, 0, 0,  1, 302, 394, 0, 0);
    add(6, 1, 0,  8, 302, 394, 0, 0);
    add(1, 1, 0,  1, 302, 394, 1, 1);
    add(1, 0, 0,  6, 302, 394, 1, 0);
    add(3, 1, 1,  1, 302, 394, 3, 1);
    add(3, 1, 1, 15, 302, 394, 3, 2);
    add(3, 1, 0,  8, 302, 398, 3, 2);
    add(3, 1, 0,  3, 302, 398, 3, 2);
    add(2, 1, 0,  1, 302, 398, 2, 1);
    add(2, 1, 0, 12, 302, 396, 2, 2);
    add(1, 1, 0,  1, 302, 396, 1, 1);
    add(1, 1, 0,  4, 302, 396, 1, 1);
    add(0, 1, 0,  1, 302, 396, 0, 1);
    add(0, 1, 0,  9, 302, 396, 0, 2);
    add(0, 1, 0,  1, 300, 396, 0, 2);

    do_reset();
    check("reset_x", int'(px[0]), 304);
    check("reset_y", int'(py[0]), 400);
    check("reset_heading", int'(hd[0]), 2);
    check("reset_state", int'(st[0]), 0);

    foreach (tbl[r]) begin
      direct  = 3'(tbl[r].dir);
      moving  = tbl[r].mv[0];
      blocked = tbl[r].blk[0];
      for (int k = 0; k < tbl[r].n; k++) cycle();
      check($sformatf("row%0d_x", r), int'(px[0]), tbl[r].ex);
      check($sformatf("row%0d_y", r), int'(py[0]), tbl[r].ey);
      check($sformatf("row%0d_heading", r), int'(hd[0]), tbl[r].ehd);
      check($sformatf("row%0d_state", r), int'(st[0]), tbl[r].est);
    end

    // Wall clamps on the edge tank: x=1 LEFT, then y=447 DOWN.
    do_reset();
    direct = 3'b000;
    moving = 1'b1;
    repeat (12) cycle();
    check("left_clamp_x", int'(px[1]), 0);
    check("left_clamp_step", int'(sp[1]), 1);
    repeat (4) cycle();
    check("left_wall_x", int'(px[1]), 0);
    check("left_wall_bump", int'(bp[1]), 1);
    check("left_wall_nostep", int'(sp[1]), 0);
    direct = 3'b011;
    repeat (12) cycle();
    check("down_clamp_y", int'(py[1]), 448);
    check("down_clamp_step", int'(sp[1]), 1);
    repeat (4) cycle();
    check("down_wall_y", int'(py[1]), 448);
    check("down_wall_bump", int'(bp[1]), 1);
    check("pre_rst_step", int'(sp[0]), 1);
    check("pre_rst_y", int'(py[0]), 404);

    // Asynchronous reset between clock edges, while pulses are high.
    #2;
    rst = 1'b1;
    #1;
    check("arst_x", int'(px[0]), 304);
    check("arst_y", int'(py[0]), 400);
    check("arst_heading", int'(hd[0]), 2);
    check("arst_state", int'(st[0]), 0);
    check("arst_step", int'(sp[0]), 0);
    check("arst_edge_x", int'(px[1]), 1);
    check("arst_edge_y", int'(py[1]), 447);
    check("arst_edge_bump", int'(bp[1]), 0);
    do_reset();

    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 15) == 0) direct = 3'($urandom_range(0, 7));
      moving  = ($urandom_range(0, 9) != 0);
      blocked = ($urandom_range(0, 4) == 0);
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
